qblock_scheduler: RTL
=====================

// Module: qblock_scheduler
// PURPOSE
//   Owns the question-block pickup slots on the track (QBLOCK0..3). Arbitrates pickups between
//   car1 and car2, removes each taken block from the map and regenerates it after a fixed number
//   of second ticks. Sits between the car/qblock collision detectors and the renderer
//   (OBJECT_QBLOCK visibility) and the car-effect logic (grant pulses).
// PARAMETERS
//   NUM_QBLOCK      4   number of question-block slots; slot k sits at QBLOCKk_X/Y
//   REGEN_INTERVAL  10  second ticks a taken block stays hidden (1..2^REGEN_WIDTH-1)
//   REGEN_WIDTH     4   width of each per-slot cooldown counter
//   IDX_WIDTH       2   width of the slot index, equal to clog2(NUM_QBLOCK)
// PORTS
//   i_clk             in   1           system clock
//   i_rst             in   1           synchronous, active-high reset
//   i_game_active     in   1           high while a race runs (from the game FSM)
//   i_sec_tick        in   1           one-cycle pulse, once per second
//   i_car1_hit        in   NUM_QBLOCK  bit k: car1 overlaps slot k (level)
//   i_car2_hit        in   NUM_QBLOCK  bit k: car2 overlaps slot k (level)
//   o_qblock_visible  out  NUM_QBLOCK  bit k: slot k is available and drawn
//   o_car1_grant      out  1           one-cycle pulse: car1 picked up a block
//   o_car1_grant_idx  out  IDX_WIDTH   slot index for o_car1_grant; 0 when no grant
//   o_car2_grant      out  1           one-cycle pulse: car2 picked up a block
//   o_car2_grant_idx  out  IDX_WIDTH   slot index for o_car2_grant; 0 when no grant
// BEHAVIOUR
// - Per-slot state is AVAIL or COOLDOWN, plus cnt[k] (REGEN_WIDTH bits).
//   o_qblock_visible[k] = (state == AVAIL). All outputs are registered.
// - Reset: all slots AVAIL, all cnt = 0, visible = all ones, grants and idx = 0,
//   round-robin priority prio = car1.
// - i_game_active = 0: force all slots to AVAIL with cnt = 0 and hold grants at 0.
//   prio is kept. A falling edge during a cooldown restores that slot on the next cycle.
// - Request selection (combinational, active games only):
//   - Each car's candidate = lowest index k with hit[k] & AVAIL[k].
//   - Hits on COOLDOWN slots are ignored.
// - Arbitration:
//   - Different candidates: both cars are granted in the same cycle.
//   - Same candidate: the prio car wins, the loser gets no grant that cycle, and prio toggles.
//   - prio changes only on a contested cycle.
// - Grant latency is 1 cycle. On the clock edge after the hit is sampled:
//   - grant = 1 and idx = k;
//   - slot k -> COOLDOWN with cnt = REGEN_INTERVAL;
//   - visible[k] = 0 on that same edge.
// - Grants are single-cycle pulses. A car never gets two grants in one cycle.
// - Cooldown:
//   - Each i_sec_tick decrements cnt[k].
//   - A tick with cnt == 1 sets AVAIL and cnt = 0 instead.
//   - A tick coinciding with the grant edge does not count. The slot is hidden for exactly
//     REGEN_INTERVAL ticks after the grant.
// - Hits are level-sensitive. A car still overlapping a slot when it regenerates is granted
//   again 1 cycle after visible rises.
// - A slot regenerating on the same cycle as a hit is not grantable until the following cycle.
// - cnt never underflows or wraps. cnt == 0 only while AVAIL.
// TESTING
// - Reset, game active, no hits -> visible = 4'b1111, no grants, prio = car1.
// - car1_hit = 4'b0100 for 1 cycle -> next cycle car1_grant = 1, idx = 2, visible = 4'b1011;
//   after exactly 10 sec ticks visible[2] = 1.
// - Contested slot:
//   - car1_hit = car2_hit = 4'b0001 -> car1 granted idx 0, car2 no grant, prio -> car2.
//   - Same test after regen -> car2 wins.
// - car1_hit = 4'b0011, car2_hit = 4'b0010 -> car1 idx 0 and car2 idx 1 granted on the same
//   cycle; visible = 4'b1100.
// - Hold car2_hit[3] high through a cooldown -> exactly one grant per regeneration, each 1 cycle
//   after visible[3] rises.
// - Drop i_game_active at cnt = 5 -> next cycle all visible, cnt = 0, no grants while inactive.

Source files
------------

// File: rtl/qblock_scheduler.sv
// Question-block pickup scheduler: arbitrates car1/car2 pickups over the slots,
// hides each taken block for REGEN_INTERVAL second ticks, then restores it.
module qblock_scheduler #(
  parameter int NUM_QBLOCK     = 4,
  parameter int REGEN_INTERVAL = 10,
  parameter int REGEN_WIDTH    = 4,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_game_active,
  input  logic                  i_sec_tick,
  input  logic [NUM_QBLOCK-1:0] i_car1_hit,
  input  logic [NUM_QBLOCK-1:0] i_car2_hit,
  output logic [NUM_QBLOCK-1:0] o_qblock_visible,
  output logic                  o_car1_grant,
  output logic [IDX_WIDTH-1:0]  o_car1_grant_idx,
  output logic                  o_car2_grant,
  output logic [IDX_WIDTH-1:0]  o_car2_grant_idx
);

  typedef enum logic {AVAIL = 1'b0, COOLDOWN = 1'b1} slot_t;

  slot_t                  state_q [NUM_QBLOCK];
  slot_t                  state_d [NUM_QBLOCK];
  logic [REGEN_WIDTH-1:0] cnt_q   [NUM_QBLOCK];
  logic [REGEN_WIDTH-1:0] cnt_d   [NUM_QBLOCK];
  logic                   prio_q;   // 0: car1 wins a contest, 1: car2
  logic                   prio_d;

  logic                  c1_vld, c2_vld, g1, g2, contested;
  logic [IDX_WIDTH-1:0]  c1_idx, c2_idx;
  logic [NUM_QBLOCK-1:0] take;

  // Lowest-index available slot per car; scanning high to low leaves the lowest.
  always_comb begin
    c1_vld = 1'b0;
    c1_idx = '0;
    c2_vld = 1'b0;
    c2_idx = '0;
    for (int k = NUM_QBLOCK - 1; k >= 0; k--) begin
      if (i_car1_hit[k] && state_q[k] == AVAIL) begin
        c1_vld = 1'b1;
        c1_idx = IDX_WIDTH'(k);
      end
      if (i_car2_hit[k] && state_q[k] == AVAIL) begin
        c2_vld = 1'b1;
        c2_idx = IDX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    g1        = c1_vld & i_game_active;
    g2        = c2_vld & i_game_active;
    contested = g1 & g2 & (c1_idx == c2_idx);
    prio_d    = prio_q;
    if (contested) begin
      if (prio_q) g1 = 1'b0;
      else        g2 = 1'b0;
      prio_d = ~prio_q;
    end
    take = '0;
    for (int k = 0; k < NUM_QBLOCK; k++)
      take[k] = (g1 && c1_idx == IDX_WIDTH'(k)) || (g2 && c2_idx == IDX_WIDTH'(k));
  end

  // Slot next state; a taken slot was AVAIL, so a coincident tick never counts.
  always_comb begin
    for (int k = 0; k < NUM_QBLOCK; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (!i_game_active) begin
        state_d[k] = AVAIL;
        cnt_d[k]   = '0;
      end else if (take[k]) begin
        state_d[k] = COOLDOWN;
        cnt_d[k]   = REGEN_WIDTH'(REGEN_INTERVAL);
      end else if (state_q[k] == COOLDOWN && i_sec_tick) begin
        if (cnt_q[k] == REGEN_WIDTH'(1)) begin
          state_d[k] = AVAIL;
          cnt_d[k]   = '0;
        end else begin
          cnt_d[k] = cnt_q[k] - REGEN_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_QBLOCK; k++) begin
        state_q[k] <= AVAIL;
        cnt_q[k]   <= '0;
      end
      prio_q           <= 1'b0;
      o_qblock_visible <= '1;
      o_car1_grant     <= 1'b0;
      o_car1_grant_idx <= '0;
      o_car2_grant     <= 1'b0;
      o_car2_grant_idx <= '0;
    end else begin
      for (int k = 0; k < NUM_QBLOCK; k++) begin
        state_q[k]          <= state_d[k];
        cnt_q[k]            <= cnt_d[k];
        o_qblock_visible[k] <= (state_d[k] == AVAIL);
      end
      prio_q           <= prio_d;
      o_car1_grant     <= g1;
      o_car1_grant_idx <= g1 ? c1_idx : '0;
      o_car2_grant     <= g2;
      o_car2_grant_idx <= g2 ? c2_idx : '0;
    end
  end

endmodule
